// File: rtl/button_press_counter.sv
// button_press_counter: synchronises and debounces a raw push-button, emitting press/release/long-press
// pulses and a wrapping press count.
module button_press_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 btn_in,
    input  logic                 clear,
    output logic                 press_pulse,
    output logic                 release_pulse,
    output logic                 long_press,
    output logic                 btn_state,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int MAXC = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] DEB_END  = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] LONG_END = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          long_done, long_done_nx;
    logic          press_nx, release_nx, long_nx;
    logic          btn_m, btn_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= btn_in;
            btn_s <= btn_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= '0;
            long_done     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            btn_state     <= 1'b0;
            count         <= '0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            long_done     <= long_done_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            long_press    <= long_nx;
            btn_state     <= (state_nx == HELD) || (state_nx == RELEASE_WAIT);
            count         <= clear ? '0 : count + CNT_WIDTH'(press_nx);
        end
    end

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        long_done_nx = long_done;
        press_nx     = 1'b0;
        release_nx   = 1'b0;
        long_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nx = PRESS_WAIT;
                    timer_nx = T_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (timer == DEB_END) begin
                    state_nx = HELD;
                    press_nx = 1'b1;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + T_ONE;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nx = RELEASE_WAIT;
                    timer_nx = T_ONE;
                end else if (timer == LONG_END && !long_done) begin
                    long_nx      = 1'b1;
                    long_done_nx = 1'b1;
                end else if (timer != '1) begin
                    // saturate so a very long hold cannot wrap back onto LONG_END
                    timer_nx = timer + T_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nx = HELD;
                    timer_nx = '0;
                end else if (timer == DEB_END) begin
                    state_nx     = IDLE;
                    release_nx   = 1'b1;
                    long_done_nx = 1'b0;
                    timer_nx     = '0;
                end else begin
                    timer_nx = timer + T_ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_button_press_counter.sv
// tb_button_press_counter: directed and random stimulus against a run-length reference model of the debouncer.
module tb_button_press_counter;
    localparam int DEB = 4;
    localparam int LONG = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          btn_in = 1'b0;
    logic          clear = 1'b0;
    logic          press_pulse, release_pulse, long_press, btn_state;
    logic [CW-1:0] count;

    button_press_counter #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .clear(clear),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_press(long_press),
        .btn_state(btn_state), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_press = 0, n_rel = 0, n_long = 0;

    // reference model: sampled-level pipeline plus run lengths of ones/zeros
    logic          m_s1, m_s2, m_d, m_ld, m_p, m_r, m_l;
    logic [CW-1:0] m_cnt;
    int            ones, zeros;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        m_s1 = 0; m_s2 = 0; m_d = 0; m_ld = 0; m_p = 0; m_r = 0; m_l = 0;
        m_cnt = '0; ones = 0; zeros = 0;
    endtask

    task automatic medge();
        logic bs;
        bs = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_in;
        m_p = 0; m_r = 0; m_l = 0;
        if (bs) begin
            // a return to 1 while held restarts the long-press interval from zero
            ones = (m_d && zeros > 0) ? 0 : ones + 1;
            zeros = 0;
        end else begin
            zeros++;
            ones = 0;
        end
        if (!m_d && ones == DEB) begin
            m_d = 1; m_p = 1; ones = 0;
        end else if (m_d && bs && ones == LONG && !m_ld) begin
            m_l = 1; m_ld = 1;
        end else if (m_d && !bs && zeros == DEB) begin
            m_d = 0; m_r = 1; m_ld = 0; zeros = 0;
        end
        m_cnt = clear ? '0 : m_cnt + CW'(m_p);
    endtask

    task automatic compare();
        check("press", press_pulse, m_p);
        check("release", release_pulse, m_r);
        check("long", long_press, m_l);
        check("state", btn_state, m_d);
        check("count", count, m_cnt);
        n_press += press_pulse;
        n_rel += release_pulse;
        n_long += long_press;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) medge(); else mreset();
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_press(input string tag, output int edges);
        bit seen;
        seen = 0;
        edges = 0;
        while (!seen && edges < 40) begin
            tick();
            edges++;
            seen = press_pulse;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1;
        mreset();
        check("rst_state", btn_state, 0);
        check("rst_count", count, 0);
        check("rst_pulses", {press_pulse, release_pulse, long_press}, 0);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int e, pe, le, p0, r0, l0;
        mreset();
        #1 reset_n = 1'b0;
        ticks(3);
        reset_n = 1'b1;
        ticks(20);
        check("reset_count", count, 0);

        btn_in = 1'b1;
        pe = 0; le = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (press_pulse && pe == 0) pe = i;
            if (long_press && le == 0) le = i;
        end
        check("press_edge", pe, 6);
        check("long_delay", le - pe, LONG);
        check("long_once", n_long, 1);
        check("press_count", count, 1);
        check("press_state", btn_state, 1);
        btn_in = 1'b0;
        ticks(10);
        check("release_once", n_rel, 1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        p0 = n_press; r0 = n_rel; l0 = n_long;
        for (int i = 0; i < 4; i++) begin
            btn_in = ~i[0];
            tick();
        end
        btn_in = 1'b0;
        ticks(12);
        check("bounce_pulses", n_press + n_rel + n_long - p0 - r0 - l0, 0);
        check("bounce_count", count, 0);
        check("bounce_state", btn_state, 0);

        btn_in = 1'b1;
        wait_press("glitch", e);
        p0 = n_press; r0 = n_rel; l0 = n_long;
        ticks(2);
        btn_in = 1'b0;
        ticks(2);
        btn_in = 1'b1;
        ticks(30);
        check("glitch_release", n_rel - r0, 0);
        check("glitch_press", n_press - p0, 0);
        check("glitch_long", n_long - l0, 1);
        check("glitch_count", count, 1);
        btn_in = 1'b0;
        ticks(10);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 17; i++) begin
            btn_in = 1'b1;
            ticks(8);
            btn_in = 1'b0;
            ticks(8);
        end
        check("wrap_count", count, 1);
        btn_in = 1'b1;
        wait_press("clear", e);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", count, 0);
        ticks(2);
        mid_reset();
        wait_press("held_reset", e);
        check("held_reset_edge", e, DEB + 2);
        btn_in = 1'b0;
        ticks(10);

        btn_in = 1'b1;
        ticks(3);
        mid_reset();
        wait_press("pw_reset", e);
        check("pw_reset_edge", e, DEB + 2);
        check("pw_reset_count", count, 1);
        btn_in = 1'b0;
        ticks(10);

        for (int seg = 0; seg < 300; seg++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode < 6) begin
                btn_in = ~btn_in;
                for (int k = int'($urandom_range(1, 25)); k > 0; k--) begin
                    clear = ($urandom_range(0, 19) == 0);
                    tick();
                end
            end else if (mode < 9) begin
                for (int k = int'($urandom_range(1, 6)); k > 0; k--) begin
                    btn_in = 1'($urandom);
                    clear = 1'b0;
                    tick();
                end
            end else begin
                clear = 1'b0;
                mid_reset();
            end
        end
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
